video_rx_capture: RTL



---
 rtl/video_rx_capture.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/video_rx_capture.sv
// Parallel RGB video receiver: registers the pins, recovers frame boundaries from VD/DEN,
// buffers active pixels in a show-ahead FIFO as an SOP/EOP stream and measures geometry.
module video_rx_capture #(
  parameter int unsigned H_ACTIVE        = 800,
  parameter int unsigned V_ACTIVE        = 480,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] video_RGB_IN,
  input  logic        video_HD,
  input  logic        video_VD,
  input  logic        video_DEN,
  output logic [23:0] st_data,
  output logic        st_valid,
  input  logic        st_ready,
  output logic        st_sop,
  output logic        st_eop,
  output logic [15:0] meas_width,
  output logic [15:0] meas_height,
  output logic        locked,
  output logic        overflow,
  input  logic        clr_overflow
);

  localparam int unsigned AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [31:0] FRAME_PIX = 32'(H_ACTIVE * V_ACTIVE);
  localparam logic [15:0] H_C       = 16'(H_ACTIVE);
  localparam logic [15:0] V_C       = 16'(V_ACTIVE);

  typedef enum logic [1:0] {WAIT_VD, WAIT_DEN, ACTIVE} state_t;

  logic [23:0] rgb_q;
  logic        vd_q, vd_prev_q, hd_q, hd_prev_q, den_q, den_prev_q;
  logic        fs, le, hs;

  state_t      state_q, state_d;
  logic [31:0] pix_cnt_q, pix_cnt_d;
  logic        push_req, push_sop, push_eop, push_ok, pop, full, ovf_evt;
  logic [25:0] push_word, head;

  logic [25:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic [15:0] line_cnt_q, row_cnt_q, hd_cnt_q, row_inc, hd_inc, width_now;
  logic [15:0] meas_width_q, meas_height_q;
  logic        seen_q, good_run_q, locked_q, overflow_q, frame_good;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q      <= '0;
      vd_q       <= 1'b0;
      vd_prev_q  <= 1'b0;
      hd_q       <= 1'b0;
      hd_prev_q  <= 1'b0;
      den_q      <= 1'b0;
      den_prev_q <= 1'b0;
    end else begin
      rgb_q      <= video_RGB_IN;
      vd_q       <= video_VD ^ SYNC_ACTIVE_LOW;
      hd_q       <= video_HD ^ SYNC_ACTIVE_LOW;
      den_q      <= video_DEN;
      vd_prev_q  <= vd_q;
      hd_prev_q  <= hd_q;
      den_prev_q <= den_q;
    end
  end

  assign fs = vd_q & ~vd_prev_q;
  assign le = den_prev_q & ~den_q;
  assign hs = hd_q & ~hd_prev_q;

  assign full     = (count_q == DEPTH_C);
  assign st_valid = (count_q != '0);
  assign pop      = st_valid & st_ready;
  assign push_ok  = push_req & (~full | pop);
  assign ovf_evt  = push_req & full & ~pop;
  assign push_word = {push_sop, push_eop, rgb_q};

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    push_req  = 1'b0;
    push_sop  = 1'b0;
    push_eop  = 1'b0;
    unique case (state_q)
      WAIT_VD: if (fs) state_d = WAIT_DEN;
      WAIT_DEN: begin
        if (den_q) begin
          push_req  = 1'b1;
          push_sop  = 1'b1;
          pix_cnt_d = 32'd1;
          push_eop  = (FRAME_PIX == 32'd1);
          state_d   = push_eop ? WAIT_VD : ACTIVE;
        end
      end
      ACTIVE: begin
        // A frame start before the pixel budget is reached restarts capture without EOP.
        if (fs) begin
          state_d = WAIT_DEN;
        end else if (den_q) begin
          push_req  = 1'b1;
          pix_cnt_d = pix_cnt_q + 32'd1;
          if (pix_cnt_d == FRAME_PIX) begin
            push_eop = 1'b1;
            state_d  = WAIT_VD;
          end
        end
      end
      default: state_d = WAIT_VD;
    endcase
    if (ovf_evt) state_d = WAIT_VD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_VD;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  always_comb begin
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign head    = mem_q[rd_ptr_q];
  assign st_data = st_valid ? head[23:0] : '0;
  assign st_sop  = st_valid & head[25];
  assign st_eop  = st_valid & head[24];

  always_ff @(posedge clk) begin
    if (reset)        overflow_q <= 1'b0;
    else if (ovf_evt) overflow_q <= 1'b1;
    else if (clr_overflow) overflow_q <= 1'b0;
  end

  always_comb begin
    row_inc = row_cnt_q;
    if (le && (row_cnt_q != '1)) row_inc = row_cnt_q + 16'd1;
    hd_inc = hd_cnt_q;
    if (hs && (hd_cnt_q != '1)) hd_inc = hd_cnt_q + 16'd1;
    width_now  = le ? line_cnt_q : meas_width_q;
    // HD pulses must cover every counted line for the frame to be trusted.
    frame_good = (width_now == H_C) && (row_inc == V_C) && (hd_inc >= row_inc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt_q    <= '0;
      row_cnt_q     <= '0;
      hd_cnt_q      <= '0;
      meas_width_q  <= '0;
      meas_height_q <= '0;
      seen_q        <= 1'b0;
      good_run_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      if (le) begin
        meas_width_q <= line_cnt_q;
        line_cnt_q   <= '0;
      end else if (den_q && (line_cnt_q != '1)) begin
        line_cnt_q <= line_cnt_q + 16'd1;
      end
      if (fs) begin
        meas_height_q <= row_inc;
        row_cnt_q     <= '0;
        hd_cnt_q      <= '0;
        seen_q        <= 1'b1;
        if (seen_q) begin
          good_run_q <= frame_good;
          locked_q   <= frame_good & good_run_q;
        end
      end else begin
        row_cnt_q <= row_inc;
        hd_cnt_q  <= hd_inc;
      end
    end
  end

  assign meas_width  = meas_width_q;
  assign meas_height = meas_height_q;
  assign locked      = locked_q;
  assign overflow    = overflow_q;

endmodule
